// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer for the word-addressed data memory.
//   Port 0 (pipeline MEM stage) and port 1 (loader/debug master) each issue
//   single-word reads/writes over a level REQ / pulsed ACK handshake. One
//   transaction at a time runs IDLE -> ACCESS -> RESP. Read data is registered
//   per port and returned with a one-cycle ACK.
// Ports:
//   CLK, ARB_reset (async, active-low)
//   REQ_p, WE_p, ADDR_p, WDATA_p     requester p inputs (p = 0, 1)
//   ACK_p, ERR_p, RDATA_p            requester p responses
//   BUSY                             high while not IDLE
//   MEM_WE, MEM_A, MEM_WD, MEM_RD    memory side (MEM_RD combinational on MEM_A)
// Configuration:
//   ARB_RR_EN defined   -> round-robin on simultaneous requests
//   ARB_RR_EN undefined -> fixed priority, port 0 wins ties
module dm_arbiter #(
  parameter int unsigned DEPTH_W = 10
) (
  input  logic        CLK,
  input  logic        ARB_reset,
  input  logic        REQ_0,
  input  logic        WE_0,
  input  logic [31:0] ADDR_0,
  input  logic [31:0] WDATA_0,
  output logic        ACK_0,
  output logic        ERR_0,
  output logic [31:0] RDATA_0,
  input  logic        REQ_1,
  input  logic        WE_1,
  input  logic [31:0] ADDR_1,
  input  logic [31:0] WDATA_1,
  output logic        ACK_1,
  output logic        ERR_1,
  output logic [31:0] RDATA_1,
  output logic        BUSY,
  output logic        MEM_WE,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_WD,
  input  logic [31:0] MEM_RD
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          g;        // granted port of the transaction in flight
  logic          we_q;
  logic          err_q;

  logic          win_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;
  logic          sel_err_c;

  // Winner selection: a lone requester always wins.
`ifdef ARB_RR_EN
  logic last_grant;
  // On a tie the port that did not win last time is served.
  assign win_c = REQ_1 & (~REQ_0 | ~last_grant);
`else
  assign win_c = REQ_1 & ~REQ_0;
`endif

  // Mux the winner's request fields and classify misaligned/out-of-range.
  always_comb begin
    sel_we_c    = win_c ? WE_1    : WE_0;
    sel_addr_c  = win_c ? ADDR_1  : ADDR_0;
    sel_wdata_c = win_c ? WDATA_1 : WDATA_0;
    sel_err_c   = (sel_addr_c[1:0] != 2'b00) ||
                  ((sel_addr_c >> (DEPTH_W + 2)) != '0);
  end

  // Sequencer: memory strobes are registered on entry to ACCESS so they are
  // live for exactly that cycle; responses are registered on entry to RESP.
  always_ff @(posedge CLK or negedge ARB_reset) begin
    if (!ARB_reset) begin
      state   <= IDLE;
      g       <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      ACK_0   <= 1'b0;
      ERR_0   <= 1'b0;
      RDATA_0 <= '0;
      ACK_1   <= 1'b0;
      ERR_1   <= 1'b0;
      RDATA_1 <= '0;
      BUSY    <= 1'b0;
      MEM_WE  <= 1'b0;
      MEM_A   <= '0;
      MEM_WD  <= '0;
`ifdef ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (REQ_0 || REQ_1) begin
            state  <= ACCESS;
            BUSY   <= 1'b1;
            g      <= win_c;
            we_q   <= sel_we_c;
            err_q  <= sel_err_c;
            MEM_WE <= sel_we_c & ~sel_err_c;
            MEM_A  <= AW'(sel_addr_c[DEPTH_W+1:2]);
            MEM_WD <= sel_wdata_c;
`ifdef ARB_RR_EN
            last_grant <= win_c;
`endif
          end
        end
        ACCESS: begin
          state  <= RESP;
          MEM_WE <= 1'b0;
          MEM_A  <= '0;
          MEM_WD <= '0;
          // Errored transactions clear the port's read data; clean writes keep it.
          if (g) begin
            ACK_1 <= 1'b1;
            ERR_1 <= err_q;
            if (err_q)      RDATA_1 <= '0;
            else if (!we_q) RDATA_1 <= MEM_RD;
          end else begin
            ACK_0 <= 1'b1;
            ERR_0 <= err_q;
            if (err_q)      RDATA_0 <= '0;
            else if (!we_q) RDATA_0 <= MEM_RD;
          end
        end
        RESP: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          ACK_0 <= 1'b0;
          ERR_0 <= 1'b0;
          ACK_1 <= 1'b0;
          ERR_1 <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a behavioural memory.
module tb_dm_arbiter;

  logic        CLK = 1'b0;
  logic        ARB_reset;
  logic        REQ_0, WE_0, REQ_1, WE_1;
  logic [31:0] ADDR_0, WDATA_0, ADDR_1, WDATA_1;
  logic        ACK_0, ERR_0, ACK_1, ERR_1, BUSY, MEM_WE;
  logic [31:0] RDATA_0, RDATA_1, MEM_A, MEM_WD, MEM_RD;

  dm_arbiter #(.DEPTH_W(10)) dut (
    .CLK(CLK), .ARB_reset(ARB_reset),
    .REQ_0(REQ_0), .WE_0(WE_0), .ADDR_0(ADDR_0), .WDATA_0(WDATA_0),
    .ACK_0(ACK_0), .ERR_0(ERR_0), .RDATA_0(RDATA_0),
    .REQ_1(REQ_1), .WE_1(WE_1), .ADDR_1(ADDR_1), .WDATA_1(WDATA_1),
    .ACK_1(ACK_1), .ERR_1(ERR_1), .RDATA_1(RDATA_1),
    .BUSY(BUSY), .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;

  // Behavioural memory: combinational read, write on rising edge.
  logic [31:0] mem [1024];
  assign MEM_RD = mem[MEM_A[9:0]];
  int          we_cnt = 0;
  logic [31:0] last_we_a = '0;
  always @(posedge CLK) begin
    if (MEM_WE) begin
      mem[MEM_A[9:0]] <= MEM_WD;
      we_cnt    = we_cnt + 1;
      last_we_a = MEM_A;
    end
  end

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every ACK pops one expected response.
  always @(negedge CLK) begin
    if (ARB_reset && (ACK_0 || ACK_1)) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", {30'd0, ACK_1, ACK_0}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_onehot", {30'd0, ACK_1, ACK_0}, e.port ? 32'd2 : 32'd1);
        chk("err",   32'(e.port ? ERR_1 : ERR_0), 32'(e.err));
        chk("rdata", e.port ? RDATA_1 : RDATA_0, e.rd);
      end
    end
  end

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      REQ_0 = req; WE_0 = we; ADDR_0 = addr; WDATA_0 = wdata;
    end else begin
      REQ_1 = req; WE_1 = we; ADDR_1 = addr; WDATA_1 = wdata;
    end
  endtask

  // One transaction from an idle bus; entered and left on a negedge in IDLE.
  task automatic issue(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rd);
    int lat = 0;
    bit got = 0;
    sb_q.push_back('{port: p[0], err: exp_err, rd: exp_rd});
    drive(p, 1'b1, we, addr, wdata);
    while (!got && lat < 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      got = (p == 0) ? ACK_0 : ACK_1;
    end
    drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("latency", 32'(lat), 32'd2);
    @(negedge CLK);
  endtask

  // Both ports held high: port 0 has four reads, port 1 has two.
  task automatic tie_test();
    logic [31:0] a0 [4];
    logic [31:0] a1 [2];
    int i0 = 0, i1 = 0, busy_low = 0, cyc = 0;
    a0 = '{32'h40, 32'h44, 32'h48, 32'h4C};
    a1 = '{32'h50, 32'h54};
`ifdef ARB_RR_EN
    sb_q.push_back('{port: 1'b0, err: 1'b0, rd: 32'hA000_0010});
    sb_q.push_back('{port: 1'b1, err: 1'b0, rd: 32'hA000_0014});
    sb_q.push_back('{port: 1'b0, err: 1'b0, rd: 32'hA000_0011});
    sb_q.push_back('{port: 1'b1, err: 1'b0, rd: 32'hA000_0015});
    sb_q.push_back('{port: 1'b0, err: 1'b0, rd: 32'hA000_0012});
    sb_q.push_back('{port: 1'b0, err: 1'b0, rd: 32'hA000_0013});
`else
    sb_q.push_back('{port: 1'b0, err: 1'b0, rd: 32'hA000_0010});
    sb_q.push_back('{port: 1'b0, err: 1'b0, rd: 32'hA000_0011});
    sb_q.push_back('{port: 1'b0, err: 1'b0, rd: 32'hA000_0012});
    sb_q.push_back('{port: 1'b0, err: 1'b0, rd: 32'hA000_0013});
    sb_q.push_back('{port: 1'b1, err: 1'b0, rd: 32'hA000_0014});
    sb_q.push_back('{port: 1'b1, err: 1'b0, rd: 32'hA000_0015});
`endif
    drive(0, 1'b1, 1'b0, a0[0], 32'd0);
    drive(1, 1'b1, 1'b0, a1[0], 32'd0);
    while ((i0 < 4 || i1 < 2) && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (!BUSY) busy_low++;
      if (ACK_0) begin
        i0++;
        if (i0 < 4) ADDR_0 = a0[i0]; else REQ_0 = 1'b0;
      end
      if (ACK_1) begin
        i1++;
        if (i1 < 2) ADDR_1 = a1[i1]; else REQ_1 = 1'b0;
      end
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("tie_done_p0", 32'(i0), 32'd4);
    chk("tie_done_p1", 32'(i1), 32'd2);
    chk("tie_busy_idle_cycles", 32'(busy_low), 32'd5);
    @(negedge CLK);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[2] = 32'h2222_2222;
    mem[4] = 32'h4444_4444;
    mem[8] = 32'hCAFE_0001;
    for (int i = 16; i < 22; i++) mem[i] = 32'hA000_0000 | 32'(i);
    ARB_reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge CLK);

    // Reset values
    chk("rst_ack0", 32'(ACK_0), 32'd0);
    chk("rst_ack1", 32'(ACK_1), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_mem_we", 32'(MEM_WE), 32'd0);
    chk("rst_mem_a", MEM_A, 32'd0);
    chk("rst_rdata0", RDATA_0, 32'd0);
    ARB_reset = 1'b1;
    @(negedge CLK);

    // Write then read back on port 0
    w0 = we_cnt;
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'd0);
    chk("wr_we_pulses", 32'(we_cnt - w0), 32'd1);
    chk("wr_mem_a", last_we_a, 32'd4);
    chk("wr_mem4", mem[4], 32'hDEAD_BEEF);
    w0 = we_cnt;
    issue(0, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'hDEAD_BEEF);
    chk("rd_no_we", 32'(we_cnt - w0), 32'd0);

    // Port isolation
    issue(1, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 32'hCAFE_0001);
    chk("iso_rdata0", RDATA_0, 32'hDEAD_BEEF);
    issue(0, 1'b1, 32'h0000_0014, 32'h0000_0055, 1'b0, 32'hDEAD_BEEF);
    chk("wr_mem5", mem[5], 32'h0000_0055);

    // Errors: misaligned write, out-of-range read
    w0 = we_cnt;
    issue(0, 1'b1, 32'h0000_0012, 32'h1111_1111, 1'b1, 32'd0);
    chk("mis_no_we", 32'(we_cnt - w0), 32'd0);
    chk("mis_mem4", mem[4], 32'hDEAD_BEEF);
    issue(1, 1'b0, 32'h0000_1000, 32'd0, 1'b1, 32'd0);
    chk("oor_rdata0_kept", RDATA_0, 32'd0);

    // Reset during the ACCESS cycle of a write
    drive(0, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678);
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_we_before", 32'(MEM_WE), 32'd1);
    chk("abort_a_before", MEM_A, 32'd2);
    ARB_reset = 1'b0;
    #1;
    chk("abort_we_after", 32'(MEM_WE), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_mem_wd", MEM_WD, 32'd0);
    chk("abort_rdata1", RDATA_1, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge CLK);
    ARB_reset = 1'b1;
    repeat (4) @(negedge CLK);
    chk("abort_mem2", mem[2], 32'h2222_2222);

    // Simultaneous requests
    tie_test();

    repeat (3) @(negedge CLK);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the word-addressed data memory. Two requesters (port 0: pipeline MEM stage, port 1: loader/debug master) issue single-word read or write transactions over a REQ/ACK handshake. The block grants one at a time, converts byte addresses to word indices, and drives the memory's write-enable/address/write-data. It also registers the combinational read data and returns it with a one-cycle ACK pulse.

## Interface
Parameters:
- DEPTH_W, 10, log2 of memory depth in words (1024 words = 4 KiB byte space)

Ports (p = 0, 1):
- CLK  in  1  system clock, all state on rising edge
- ARB_reset  in  1  reset, asynchronous, active-low
- REQ_p  in  1  request; level, held with WE_p/ADDR_p/WDATA_p stable until ACK_p
- WE_p  in  1  1 = write, 0 = read
- ADDR_p  in  32  byte address
- WDATA_p  in  32  write data
- ACK_p  out  1  one-cycle completion pulse
- ERR_p  out  1  pulses with ACK_p when the transaction was rejected
- RDATA_p  out  32  registered read data
- BUSY  out  1  high whenever state != IDLE
- MEM_WE  out  1  to memory write enable
- MEM_A  out  32  to memory address (word index, zero-extended)
- MEM_WD  out  32  to memory write data
- MEM_RD  in  32  from memory read data (combinational on MEM_A)

## Operation
- States: IDLE, ACCESS, RESP; reset state IDLE.
- IDLE: if any REQ_p is high, latch winner index g, WE, ADDR, and WDATA into internal registers, then go to ACCESS. Otherwise stay in IDLE.
- Arbitration on simultaneous requests depends on ARB_RR_EN (see Configuration). A single requester always wins.
- ACCESS (exactly one cycle):
  - MEM_A = latched ADDR[DEPTH_W+1:2].
  - MEM_WD = latched WDATA.
  - MEM_WE = latched WE & ~err.
  - On the exiting edge: if the transaction is a read without error, RDATA_g <= MEM_RD.
  - Next state: RESP.
- err = (ADDR[1:0] != 0) or (ADDR[31:DEPTH_W+2] != 0). On error, no write occurs and RDATA_g <= 0 (for both reads and writes).
- RESP: ACK_g = 1 and ERR_g = err for this cycle only. Next state: IDLE unconditionally.
- REQ_g still high on the cycle after ACK is treated as a new transaction.
- Outside ACCESS, MEM_WE = 0, MEM_A = 0, MEM_WD = 0.
- RDATA_p holds its value until the next read or errored transaction completes on that port. An error-free write does not change RDATA_p.
- The non-granted port's inputs are ignored and its outputs are unchanged. Its REQ stays pending and is re-evaluated in the next IDLE.

## Timing
- Reset values: state IDLE, ACK_p = 0, ERR_p = 0, RDATA_p = 0, BUSY = 0, MEM_* = 0, last-grant = 1.
- REQ sampled high at edge E0 → ACCESS during E0..E1. The write commits at E1 and RDATA is valid after E1. ACK is high during E1..E2.
- Latency: 2 cycles. Occupancy: 3 cycles per transaction.
- Maximum throughput: one transaction per 3 cycles, shared across both ports.
- Reset asserted mid-transaction clears state asynchronously. MEM_WE drops immediately, so a write still in ACCESS never commits. No ACK is issued for the aborted transaction.
- REQ deasserted before ACK is a protocol violation. The latched transaction still completes and ACKs.

## Configuration
- ARB_RR_EN defined: round-robin.
  - A 1-bit last-grant register updates on every IDLE→ACCESS transition.
  - On a tie, the port != last-grant wins.
  - Reset value 1, so port 0 wins the first tie.
- ARB_RR_EN undefined: fixed priority. Port 0 always wins ties, and the last-grant register is not built.

## Test plan
- Single write then read, port 0: write 0x0000_0010 ← 0xDEAD_BEEF, then read 0x0000_0010 → MEM_WE high exactly one cycle with MEM_A = 4. Read gives RDATA_0 = 0xDEAD_BEEF with ACK_0 two edges after the REQ sample. ERR_0 = 0.
- Simultaneous REQ_0/REQ_1 held for 4 transactions:
  - with ARB_RR_EN: grant order 0, 1, 0, 1.
  - without ARB_RR_EN: 0, 0, 0, 0 while REQ_0 is held.
  - BUSY never drops between back-to-back grants except in IDLE.
- Error cases:
  - Misaligned write to 0x0000_0012 → ERR_0 = 1 with ACK_0, MEM_WE never high, memory word 4 unchanged.
  - Read of 0x0000_1000 (out of range, DEPTH_W = 10) → ERR = 1 and RDATA = 0.
- Reset mid-access: assert ARB_reset low during the ACCESS cycle of a write of 0x1234_5678 to 0x8 → MEM_WE goes low immediately, no ACK, word 2 unchanged, all outputs at reset values.
- Port isolation: port 1 reads 0xCAFE_0001 while RDATA_0 holds 0xDEAD_BEEF → RDATA_0 unchanged. A port-0 error-free write leaves RDATA_0 unchanged.
